// File: rtl/control_unit.sv
// ----------------------------------------------------------------------------
// control_unit
//
// Purpose:
//   Combinational decode/sequencing block for the 8-bit accumulator CPU.
//   From the current FSM state, the instruction register and the ALU zero
//   flag it produces the next FSM state and every datapath strobe/select.
//   The state register itself lives in the datapath; this block holds no
//   storage and has zero latency.
//
// Ports:
//   clk          in   1  system clock (timing reference only, not used here)
//   reset        in   1  synchronous active-high; forces all defaults and
//                        next_state = FETCH
//   instr        in   8  IR contents: [7:5] opcode, [4:0] operand field
//   state        in   3  current FSM state
//   zf           in   1  ALU zero flag
//   next_state   out  3  state to load on the next clk edge
//   pc_we        out  1  PC write enable
//   pc_sel       out  1  0 = PC+1, 1 = jump target
//   pc_jmp_sel   out  1  0 = PC + sext(pc_offset), 1 = A (absolute)
//   pc_offset    out  4  relative jump offset
//   addr_sel     out  1  memory address: 0 = PC, 1 = {4'b0, addr_offset}
//   addr_offset  out  4  data address
//   mem_sel      out  1  memory write data: 0 = A, 1 = B
//   mem_we       out  1  memory write enable
//   alu_opcode   out  3  ALU operation
//   alu_sel_a    out  1  ALU A operand: 0 = A, 1 = B
//   alu_sel_b    out  1  ALU B operand: 0 = B, 1 = constant 1
//   alu_we       out  1  ALU result register write
//   zf_we        out  1  zero flag write
//   ir_we        out  1  IR write
//   a_sel        out  1  A source: 0 = ALU result, 1 = memory data
//   a_we         out  1  A write enable
//   b_sel        out  1  B source: 0 = memory data, 1 = A
//   b_we         out  1  B write enable
//   halt         out  1  processor halted
// ----------------------------------------------------------------------------
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic [2:0] state,
    input  logic       zf,
    output logic [2:0] next_state,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       pc_jmp_sel,
    output logic [3:0] pc_offset,
    output logic       addr_sel,
    output logic [3:0] addr_offset,
    output logic       mem_sel,
    output logic       mem_we,
    output logic [2:0] alu_opcode,
    output logic       alu_sel_a,
    output logic       alu_sel_b,
    output logic       alu_we,
    output logic       zf_we,
    output logic       ir_we,
    output logic       a_sel,
    output logic       a_we,
    output logic       b_sel,
    output logic       b_we,
    output logic       halt
);

    // FSM state encodings (code 3'b111 is unused and decodes like IDLE)
    localparam logic [2:0] S_FETCH     = 3'b000;
    localparam logic [2:0] S_DECODE    = 3'b001;
    localparam logic [2:0] S_EXECUTE   = 3'b010;
    localparam logic [2:0] S_MEMORY    = 3'b011;
    localparam logic [2:0] S_WRITEBACK = 3'b100;
    localparam logic [2:0] S_HALT      = 3'b101;

    // Opcodes in instr[7:5]
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_STA = 3'b010;
    localparam logic [2:0] OP_LDB = 3'b011;
    localparam logic [2:0] OP_ALU = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    // The clock only times the external state register; keep it visibly
    // consumed so it does not read as a dangling input.
    logic unused_clk;
    assign unused_clk = clk;

    logic [2:0] opcode;
    assign opcode = instr[7:5];

    always_comb begin
        next_state  = S_FETCH;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        pc_jmp_sel  = 1'b0;
        pc_offset   = 4'd0;
        addr_sel    = 1'b0;
        addr_offset = 4'd0;
        mem_sel     = 1'b0;
        mem_we      = 1'b0;
        alu_opcode  = 3'd0;
        alu_sel_a   = 1'b0;
        alu_sel_b   = 1'b0;
        alu_we      = 1'b0;
        zf_we       = 1'b0;
        ir_we       = 1'b0;
        a_sel       = 1'b0;
        a_we        = 1'b0;
        b_sel       = 1'b0;
        b_we        = 1'b0;
        halt        = 1'b0;

        if (!reset) begin
            case (state)
                S_FETCH: begin
                    // Read memory at PC into IR and advance PC by one.
                    addr_sel   = 1'b0;
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    pc_sel     = 1'b0;
                    next_state = S_DECODE;
                end

                S_DECODE: begin
                    case (opcode)
                        OP_NOP:         next_state = S_FETCH;
                        OP_LDA, OP_STA: next_state = S_MEMORY;
                        // LDB with instr[4]=1 is a register move B<-A and
                        // needs no memory access.
                        OP_LDB:         next_state = instr[4] ? S_EXECUTE : S_MEMORY;
                        OP_ALU, OP_JMP,
                        OP_JZ:          next_state = S_EXECUTE;
                        OP_HLT:         next_state = S_HALT;
                        default:        next_state = S_FETCH;
                    endcase
                end

                S_MEMORY: begin
                    if (opcode == OP_LDA || opcode == OP_STA || opcode == OP_LDB) begin
                        addr_sel    = 1'b1;
                        addr_offset = instr[3:0];
                    end
                    case (opcode)
                        OP_LDA: begin
                            a_sel = 1'b1;
                            a_we  = 1'b1;
                        end
                        OP_STA: begin
                            mem_sel = 1'b0;
                            mem_we  = 1'b1;
                        end
                        OP_LDB: begin
                            b_sel = 1'b0;
                            b_we  = 1'b1;
                        end
                        default: ;
                    endcase
                end

                S_EXECUTE: begin
                    case (opcode)
                        OP_ALU: begin
                            alu_opcode = instr[2:0];
                            alu_sel_a  = instr[4];
                            alu_sel_b  = instr[3];
                            alu_we     = 1'b1;
                            zf_we      = 1'b1;
                            next_state = S_WRITEBACK;
                        end
                        OP_LDB: begin
                            if (instr[4]) begin
                                b_sel = 1'b1;
                                b_we  = 1'b1;
                            end
                        end
                        OP_JMP, OP_JZ: begin
                            // JZ falls back to defaults when the flag is clear.
                            if (opcode == OP_JMP || zf) begin
                                pc_we      = 1'b1;
                                pc_sel     = 1'b1;
                                pc_jmp_sel = instr[4];
                                pc_offset  = instr[3:0];
                            end
                        end
                        default: ;
                    endcase
                end

                S_WRITEBACK: begin
                    if (opcode == OP_ALU) begin
                        a_sel = 1'b0;
                        a_we  = 1'b1;
                    end
                end

                S_HALT: begin
                    // Sticky until reset.
                    halt       = 1'b1;
                    next_state = S_HALT;
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// ----------------------------------------------------------------------------
// tb_control_unit
//
// Purpose:
//   Self-checking bench for control_unit: directed steps followed by random
//   (reset, state, instr, zf) combinations compared against a behavioural
//   model of the instruction set's control behaviour.
// ----------------------------------------------------------------------------
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic [7:0] instr;
    logic [2:0] state;
    logic       zf;
    logic [2:0] next_state;
    logic       pc_we, pc_sel, pc_jmp_sel;
    logic [3:0] pc_offset;
    logic       addr_sel;
    logic [3:0] addr_offset;
    logic       mem_sel, mem_we;
    logic [2:0] alu_opcode;
    logic       alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we;
    logic       a_sel, a_we, b_sel, b_we, halt;

    int n_checks = 0;
    int n_fails  = 0;

    control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .state      (state),
        .zf         (zf),
        .next_state (next_state),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .pc_jmp_sel (pc_jmp_sel),
        .pc_offset  (pc_offset),
        .addr_sel   (addr_sel),
        .addr_offset(addr_offset),
        .mem_sel    (mem_sel),
        .mem_we     (mem_we),
        .alu_opcode (alu_opcode),
        .alu_sel_a  (alu_sel_a),
        .alu_sel_b  (alu_sel_b),
        .alu_we     (alu_we),
        .zf_we      (zf_we),
        .ir_we      (ir_we),
        .a_sel      (a_sel),
        .a_we       (a_we),
        .b_sel      (b_sel),
        .b_we       (b_we),
        .halt       (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every output in one 31-bit word, in port order.
    logic [30:0] obs;
    assign obs = {next_state, pc_we, pc_sel, pc_jmp_sel, pc_offset, addr_sel,
                  addr_offset, mem_sel, mem_we, alu_opcode, alu_sel_a,
                  alu_sel_b, alu_we, zf_we, ir_we, a_sel, a_we, b_sel, b_we, halt};

    // Behavioural model: describe what each instruction does at each step of
    // its life (fetch, decode, the one or two work steps, halt) and build the
    // output word from named fields.
    function automatic logic [30:0] model(input logic r, input logic [2:0] st,
                                          input logic [7:0] ins, input logic z);
        logic [2:0] ns;
        logic p_we, p_sel, p_jsel, ad_sel, m_sel, m_we;
        logic [3:0] p_off, ad_off;
        logic [2:0] aop;
        logic asa, asb, awe, zwe, iwe, as, ae, bs, be, h;
        int op;
        bit move_b;
        ns = 3'd0; p_we = 0; p_sel = 0; p_jsel = 0; p_off = 0; ad_sel = 0;
        ad_off = 0; m_sel = 0; m_we = 0; aop = 0; asa = 0; asb = 0; awe = 0;
        zwe = 0; iwe = 0; as = 0; ae = 0; bs = 0; be = 0; h = 0;
        op = int'(ins[7:5]);
        move_b = (op == 3) && ins[4];
        if (!r) begin
            if (st == 3'd0) begin                      // FETCH
                iwe = 1; p_we = 1; ns = 3'd1;
            end else if (st == 3'd1) begin             // DECODE
                if (op == 0)                         ns = 3'd0;
                else if (op == 7)                    ns = 3'd5;
                else if (op >= 4 || move_b)          ns = 3'd2;
                else                                 ns = 3'd3;
            end else if (st == 3'd3) begin             // MEMORY
                if (op >= 1 && op <= 3) begin
                    ad_sel = 1; ad_off = ins[3:0];
                    if (op == 1) begin as = 1; ae = 1; end
                    if (op == 2) m_we = 1;
                    if (op == 3) be = 1;
                end
            end else if (st == 3'd2) begin             // EXECUTE
                if (op == 4) begin
                    aop = ins[2:0]; asa = ins[4]; asb = ins[3];
                    awe = 1; zwe = 1; ns = 3'd4;
                end else if (move_b) begin
                    bs = 1; be = 1;
                end else if (op == 5 || (op == 6 && z)) begin
                    p_we = 1; p_sel = 1; p_jsel = ins[4]; p_off = ins[3:0];
                end
            end else if (st == 3'd4) begin             // WRITEBACK
                if (op == 4) ae = 1;
            end else if (st == 3'd5) begin             // HALT
                h = 1; ns = 3'd5;
            end
        end
        return {ns, p_we, p_sel, p_jsel, p_off, ad_sel, ad_off, m_sel, m_we,
                aop, asa, asb, awe, zwe, iwe, as, ae, bs, be, h};
    endfunction

    // Apply inputs mid-cycle and let the combinational outputs settle.
    task automatic drive(input logic r, input logic [2:0] st,
                         input logic [7:0] ins, input logic z);
        @(negedge clk);
        reset = r; state = st; instr = ins; zf = z;
        #1;
    endtask

    task automatic chk(input string tag, input logic [30:0] o, input logic [30:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fails++;
            $display("FAIL %s observed=%h expected=%h (reset=%b state=%0d instr=%h zf=%b)",
                     tag, o, e, reset, state, instr, zf);
            $error("%s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_model(input string tag);
        chk(tag, obs, model(reset, state, instr, zf));
    endtask

    initial begin
        logic [7:0] idle_instrs [7];
        logic [7:0] ri;
        logic [2:0] rs;
        logic rr, rz;
        idle_instrs = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0};
        reset = 1'b1; state = 3'd0; instr = 8'h00; zf = 1'b0;

        // IDLE: everything zero for each instr
        foreach (idle_instrs[k]) begin
            drive(1'b0, 3'd6, idle_instrs[k], 1'b1);
            chk("idle", obs, 31'd0);
        end
        // Unused state code behaves like IDLE
        drive(1'b0, 3'd7, 8'hE5, 1'b1);
        chk("state111", obs, 31'd0);

        // Reset overrides HALT
        drive(1'b1, 3'd5, 8'hE0, 1'b1);
        chk("reset_halt", obs, 31'd0);

        // Fetch -> decode HLT -> halt
        drive(1'b0, 3'd0, 8'hE0, 1'b0);
        chk("fetch_ns", {28'd0, next_state}, 31'd1);
        chk("fetch_we", {29'd0, ir_we, pc_we}, 31'd3);
        chk_model("fetch_all");
        drive(1'b0, 3'd1, 8'hE0, 1'b0);
        chk("decode_hlt", {28'd0, next_state}, 31'd5);
        drive(1'b0, 3'd5, 8'hE0, 1'b0);
        chk("halt", {27'd0, halt, next_state}, {27'd0, 1'b1, 3'd5});

        // ALU then writeback
        drive(1'b0, 3'd2, 8'b100_0_1_000, 1'b0);
        chk("alu_exec", {22'd0, alu_opcode, alu_sel_a, alu_sel_b, alu_we, zf_we, next_state},
            {22'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 3'd4});
        chk_model("alu_exec_all");
        drive(1'b0, 3'd4, 8'b100_0_1_000, 1'b0);
        chk("alu_wb", {26'd0, a_we, a_sel, next_state}, {26'd0, 1'b1, 1'b0, 3'd0});

        // JZ taken / not taken
        drive(1'b0, 3'd2, 8'hC5, 1'b1);
        chk("jz_taken", {25'd0, pc_we, pc_sel, pc_offset}, {25'd0, 1'b1, 1'b1, 4'b0101});
        drive(1'b0, 3'd2, 8'hC5, 1'b0);
        chk("jz_not", {26'd0, pc_we, pc_offset}, 31'd0);
        chk("jz_not_all", obs, 31'd0);

        // Memory ops
        drive(1'b0, 3'd3, 8'h27, 1'b0);
        chk("lda_mem", {24'd0, addr_sel, addr_offset, a_sel, a_we},
            {24'd0, 1'b1, 4'b0111, 1'b1, 1'b1});
        drive(1'b0, 3'd3, 8'h43, 1'b0);
        chk("sta_mem", {30'd0, mem_we}, 31'd1);
        chk_model("sta_all");
        drive(1'b0, 3'd3, 8'h62, 1'b0);
        chk("ldb_mem", {29'd0, b_we, b_sel}, {29'd0, 1'b1, 1'b0});

        // Random sweep against the model
        for (int n = 0; n < 600; n++) begin
            rr = ($urandom_range(0, 15) == 0);
            rs = 3'($urandom_range(0, 7));
            ri = 8'($urandom);
            rz = 1'($urandom);
            drive(rr, rs, ri, rz);
            chk_model("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
